// File: rtl/phase_countdown_display_pkg.sv
// Shared constants for the phase countdown display: lamp codes, 7-seg glyphs,
// phase enumeration and small BCD helpers.
package phase_countdown_display_pkg;

    // Active-low lamp codes driven by the light controller
    localparam logic [2:0] LAMP_A    = 3'b110;
    localparam logic [2:0] LAMP_B    = 3'b101;
    localparam logic [2:0] LAMP_C    = 3'b011;
    localparam logic [2:0] LAMP_IDLE = 3'b111;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'b1011_1111;
    localparam logic [7:0] SEG_GLYPH [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic [1:0] {
        PH_INVALID = 2'd0,
        PH_A       = 2'd1,
        PH_B       = 2'd2,
        PH_C       = 2'd3
    } phase_t;

    // Map a lamp code to its phase; anything unrecognised is invalid
    function automatic phase_t phase_of(input logic [2:0] lamp);
        case (lamp)
            LAMP_A:  return PH_A;
            LAMP_B:  return PH_B;
            LAMP_C:  return PH_C;
            default: return PH_INVALID;
        endcase
    endfunction

    // Two-digit BCD of a value in 0..99
    function automatic logic [7:0] to_bcd(input int unsigned s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    // BCD down-count by one, saturating at 00
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00) return 8'h00;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment glyph; non-decimal codes blank.
module seg7_decode (
    input  logic [3:0] digit,
    output logic [7:0] glyph_c
);
    import phase_countdown_display_pkg::*;

    // Table lookup for 0..9, blank otherwise
    always_comb begin
        glyph_c = SEG_BLANK;
        if (digit < 4'd10) glyph_c = SEG_GLYPH[digit];
    end

endmodule

// File: rtl/phase_countdown_display.sv
// Seconds-remaining countdown for a three-phase traffic light, shown on a
// two-digit multiplexed 7-segment display.
// Optional feature: define COUNTDOWN_BLINK_EN to blink the last 3 seconds.
module phase_countdown_display #(
    parameter int unsigned CLK_HZ      = 27000000,
    parameter int unsigned REFRESH_DIV = 27000,
    parameter int unsigned PHASE_A_S   = 10,
    parameter int unsigned PHASE_B_S   = 3,
    parameter int unsigned PHASE_C_S   = 12
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [2:0] led_state,
    output logic [7:0] seg,
    output logic [1:0] dig_sel,
    output logic [7:0] bcd_remaining,
    output logic       err
);
    import phase_countdown_display_pkg::*;

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [7:0]  BCD_A = to_bcd(PHASE_A_S);
    localparam logic [7:0]  BCD_B = to_bcd(PHASE_B_S);
    localparam logic [7:0]  BCD_C = to_bcd(PHASE_C_S);

    // Reject illegal configurations at elaboration
    if (PHASE_A_S < 1 || PHASE_A_S > 99 || PHASE_B_S < 1 || PHASE_B_S > 99 ||
        PHASE_C_S < 1 || PHASE_C_S > 99) begin : g_bad_phase
        $error("phase durations must be in 1..99");
    end
    if (CLK_HZ < 1 || REFRESH_DIV < 1) begin : g_bad_div
        $error("CLK_HZ and REFRESH_DIV must be at least 1");
    end

    logic [2:0]    led_q;
    logic [PW-1:0] prescaler, prescaler_next;
    logic [RW-1:0] refresh, refresh_next;
    logic          slot, slot_next;
    logic          seen, seen_next;
    logic          err_next;
    logic [7:0]    bcd_next, load_bcd, seg_next;
    logic [1:0]    dig_sel_next;
    logic [3:0]    digit;
    logic [7:0]    glyph_c;
    phase_t        phase;
    logic          change, load, tick, refresh_wrap;

    // Countdown next state: load beats tick, invalid code freezes the count
    always_comb begin
        phase          = phase_of(led_state);
        change         = (led_state != led_q);
        load           = change && (phase != PH_INVALID);
        tick           = (prescaler == PW'(CLK_HZ - 1));
        prescaler_next = tick ? '0 : prescaler + PW'(1);
        bcd_next       = bcd_remaining;
        err_next       = err;
        seen_next      = seen;
        unique case (phase)
            PH_A:    load_bcd = BCD_A;
            PH_B:    load_bcd = BCD_B;
            PH_C:    load_bcd = BCD_C;
            default: load_bcd = 8'h00;
        endcase
        if (load) begin
            bcd_next       = load_bcd;
            prescaler_next = '0;
            err_next       = 1'b0;
            seen_next      = 1'b1;
        end else if (change) begin
            err_next = 1'b1;
        end else if (tick && !err) begin
            bcd_next = bcd_dec(bcd_remaining);
        end
    end

    // Digit-slot multiplexing
    always_comb begin
        refresh_wrap = (refresh == RW'(REFRESH_DIV - 1));
        refresh_next = refresh_wrap ? '0 : refresh + RW'(1);
        slot_next    = slot ^ refresh_wrap;
        dig_sel_next = slot_next ? 2'b01 : 2'b10;
    end

    assign digit = slot_next ? bcd_next[7:4] : bcd_next[3:0];

    seg7_decode u_seg7_decode (
        .digit   (digit),
        .glyph_c (glyph_c)
    );

    // Segment pattern for the slot being shown next cycle
    always_comb begin
        seg_next = glyph_c;
        if (err_next) begin
            seg_next = SEG_DASH;
        end else if (!seen_next) begin
            seg_next = SEG_BLANK;
        end else if (slot_next && bcd_next[7:4] == 4'd0) begin
            seg_next = SEG_BLANK;
        end
`ifdef COUNTDOWN_BLINK_EN
        if (!err_next && seen_next && bcd_next <= 8'h03 &&
            prescaler_next >= PW'(CLK_HZ / 2)) begin
            seg_next = SEG_BLANK;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_q         <= LAMP_IDLE;
            prescaler     <= '0;
            refresh       <= '0;
            slot          <= 1'b0;
            seen          <= 1'b0;
            err           <= 1'b0;
            bcd_remaining <= 8'h00;
            seg           <= SEG_BLANK;
            dig_sel       <= 2'b10;
        end else begin
            led_q         <= led_state;
            prescaler     <= prescaler_next;
            refresh       <= refresh_next;
            slot          <= slot_next;
            seen          <= seen_next;
            err           <= err_next;
            bcd_remaining <= bcd_next;
            seg           <= seg_next;
            dig_sel       <= dig_sel_next;
        end
    end

endmodule

// File: tb/tb_phase_countdown_display.sv
// Self-checking bench for phase_countdown_display (CLK_HZ=10, REFRESH_DIV=2).
// Honours COUNTDOWN_BLINK_EN when the same macro is defined for the build.
module tb_phase_countdown_display;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic [2:0] led_state = 3'b111;
    logic [7:0] seg;
    logic [1:0] dig_sel;
    logic [7:0] bcd_remaining;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: integer seconds, cycle-in-second, flags, edge count
    int         m_rem, m_cyc, m_k;
    bit         m_err, m_seen;
    logic [2:0] m_last;

    logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [2:0] valid_codes [3] = '{3'b110, 3'b101, 3'b011};

    phase_countdown_display #(
        .CLK_HZ      (10),
        .REFRESH_DIV (2)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .led_state     (led_state),
        .seg           (seg),
        .dig_sel       (dig_sel),
        .bcd_remaining (bcd_remaining),
        .err           (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dur_of(input logic [2:0] l);
        case (l)
            3'b110:  return 10;
            3'b101:  return 3;
            3'b011:  return 12;
            default: return 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_rem = 0; m_cyc = 0; m_k = 0; m_err = 0; m_seen = 0; m_last = 3'b111;
    endfunction

    // One clock of the countdown rules, in whole seconds
    function automatic void model_edge(input logic [2:0] l);
        int d;
        d = dur_of(l);
        if (l != m_last && d > 0) begin
            m_rem = d; m_cyc = 0; m_err = 0; m_seen = 1;
        end else begin
            if (l != m_last) m_err = 1;
            else if (m_cyc == 9 && !m_err && m_rem > 0) m_rem = m_rem - 1;
            m_cyc = (m_cyc + 1) % 10;
        end
        m_last = l;
        m_k++;
    endfunction

    function automatic logic [7:0] exp_bcd();
        return 8'((m_rem / 10) * 16 + (m_rem % 10));
    endfunction

    function automatic logic [1:0] exp_dig();
        return (((m_k / 2) % 2) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [7:0] exp_seg();
        bit tens;
        tens = (((m_k / 2) % 2) == 1);
        if (m_err) return 8'hBF;
        if (!m_seen) return 8'hFF;
        if (tens && m_rem < 10) return 8'hFF;
`ifdef COUNTDOWN_BLINK_EN
        if (m_rem <= 3 && m_cyc >= 5) return 8'hFF;
`endif
        return tens ? glyph[m_rem / 10] : glyph[m_rem % 10];
    endfunction

    // Drive one code for one clock, then compare all outputs to the model
    task automatic step(input logic [2:0] l);
        led_state = l;
        @(posedge sys_clk);
        model_edge(l);
        #1;
        check("bcd", 32'(bcd_remaining), 32'(exp_bcd()));
        check("err", 32'(err), 32'(m_err));
        check("dig_sel", 32'(dig_sel), 32'(exp_dig()));
        check("seg", 32'(seg), 32'(exp_seg()));
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        led_state = 3'b111;
        #1;
        model_reset();
        check("rst_seg", 32'(seg), 32'h0FF);
        check("rst_dig_sel", 32'(dig_sel), 32'h2);
        check("rst_bcd", 32'(bcd_remaining), 32'h00);
        check("rst_err", 32'(err), 32'h0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        bit         found;
        logic [2:0] code;
        int         len;

        do_reset();

        // Idle before any valid code: blank on both slots
        repeat (6) step(3'b111);

        // Phase A load and first decrements
        step(3'b110);
        check("load_A_10", 32'(bcd_remaining), 32'h10);
        repeat (10) step(3'b110);
        check("A_09", 32'(bcd_remaining), 32'h09);
        repeat (90) step(3'b110);
        check("A_00", 32'(bcd_remaining), 32'h00);
        repeat (20) step(3'b110);
        check("A_hold_00", 32'(bcd_remaining), 32'h00);

        // Reload A, then switch to B exactly on a tick at 05
        step(3'b111);
        step(3'b110);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_rem == 5 && m_cyc == 9) found = 1;
            else step(3'b110);
        end
        check("wait_tick_at_05", 32'(found), 32'h1);
        step(3'b101);
        check("load_wins_03", 32'(bcd_remaining), 32'h03);
        for (int i = 0; i < 9; i++) begin
            step(3'b101);
            check("B_still_03", 32'(bcd_remaining), 32'h03);
        end
        step(3'b101);
        check("B_02_after_10", 32'(bcd_remaining), 32'h02);

        // Invalid code freezes and shows dashes; then phase C recovers
        step(3'b100);
        check("err_set", 32'(err), 32'h1);
        check("err_dash", 32'(seg), 32'hBF);
        repeat (15) step(3'b100);
        check("err_frozen", 32'(bcd_remaining), 32'h02);
        step(3'b011);
        check("err_clear", 32'(err), 32'h0);
        check("load_C_12", 32'(bcd_remaining), 32'h12);

        // Single-digit value: tens blank, units glyph 7
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_rem == 7) found = 1;
            else step(3'b011);
        end
        check("wait_07", 32'(found), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(3'b011);
            check("seg_07", 32'(seg), (((m_k / 2) % 2) == 1) ? 32'hFF : 32'hF8);
        end

        // Final seconds (steady or blinking depending on build)
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_rem == 2) found = 1;
            else step(3'b011);
        end
        check("wait_02", 32'(found), 32'h1);
        repeat (20) step(3'b011);

        // Randomised code sequences
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 1) == 1) code = valid_codes[$urandom_range(0, 2)];
            else code = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 30);
            repeat (len) step(code);
        end

        // Reset in mid-countdown aborts it; a fresh change restarts
        step(3'b111);
        step(3'b110);
        repeat (25) step(3'b110);
        do_reset();
        repeat (4) step(3'b111);
        check("post_rst_blank", 32'(seg), 32'hFF);
        step(3'b110);
        check("post_rst_load", 32'(bcd_remaining), 32'h10);
        repeat (12) step(3'b110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/phase_countdown_display.md
PHASE_COUNTDOWN_DISPLAY -- requirements
Module: phase_countdown_display

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000, sys_clk cycles per second tick.
REQ-002 SHALL have parameter REFRESH_DIV, default 27000, sys_clk cycles per displayed digit slot.
REQ-003 SHALL have parameters PHASE_A_S, PHASE_B_S, PHASE_C_S, defaults 10, 3, 12, phase durations in seconds; each legal range 1..99; out-of-range values SHALL fail elaboration.
REQ-004 sys_clk  input  1  clock; all logic on rising edge.
REQ-005 sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-006 led_state  input  3  active-low lamp code from the light controller, same clock domain: 3'b110 = phase A, 3'b101 = phase B, 3'b011 = phase C; any other code is invalid.
REQ-007 seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
REQ-008 dig_sel  output  2  active-low digit enable, one-cold; bit0 = units, bit1 = tens; registered.
REQ-009 bcd_remaining  output  8  seconds remaining, two BCD digits {tens,units}, registered.
REQ-010 err  output  1  high while the last sampled led_state is invalid, registered.

Function
REQ-011 led_state SHALL be registered once (led_q); a phase change is led_state != led_q.
REQ-012 On a change to a valid code, the cycle after led_state first shows it: bcd_remaining SHALL load that phase's duration in BCD, second prescaler SHALL clear to 0, err SHALL clear.
REQ-013 On a change to an invalid code: err SHALL set next cycle, bcd_remaining SHALL hold, countdown SHALL freeze.
REQ-014 Prescaler SHALL count 0..CLK_HZ-1 and wrap; tick asserts for one cycle at CLK_HZ-1.
REQ-015 On tick with err low, bcd_remaining SHALL decrement as a BCD down-counter: units 0 borrows from tens, units wraps to 9; 00 SHALL saturate at 00.
REQ-016 Load SHALL take priority over a simultaneous tick.
REQ-017 A refresh counter 0..REFRESH_DIV-1 SHALL toggle the digit slot on wrap; dig_sel SHALL alternate 2'b10 (units) and 2'b01 (tens).
REQ-018 Segment decode: digits 0..9, standard 7-seg, dp off; a tens digit of 0 SHALL be blank (8'hFF); units SHALL always show.
REQ-019 While err is high, both digits SHALL show '-' (8'b1011_1111).
REQ-020 Before the first valid code after reset, both digits SHALL be blank.

Reset
REQ-021 Reset SHALL force: seg=8'hFF, dig_sel=2'b10, bcd_remaining=8'h00, err=0, led_q=3'b111, prescaler=0, refresh counter=0, "seen valid" flag=0.
REQ-022 Reset mid-countdown SHALL abort it; after release the block waits for a new phase change.

Configuration
REQ-023 With COUNTDOWN_BLINK_EN defined, while bcd_remaining <= 8'h03 and err low, digits SHALL blank during the second half of each second (prescaler >= CLK_HZ/2).
REQ-024 Without COUNTDOWN_BLINK_EN, display SHALL be steady and blink logic SHALL not exist.

Structure
REQ-025 A shared package SHALL hold the lamp code constants, the 7-seg glyph table (0..9, blank, dash) and the phase enumeration.
REQ-026 The 4-bit-BCD-to-segment decoder SHALL be a combinational sub-module seg7_decode; all other logic in the top.

Verification (bench uses CLK_HZ=10, REFRESH_DIV=2, defaults otherwise)
REQ-027 Reset released, led_state=3'b111 -> seg=8'hFF on both slots, bcd_remaining=8'h00, err=0.
REQ-028 led_state 3'b111->3'b110 at cycle n -> bcd_remaining=8'h10 at n+1; 8'h09 after 10 more cycles; 8'h00 after 100, holding there.
REQ-029 Phase A at 8'h05, led_state->3'b101 on the same cycle as tick -> bcd_remaining=8'h03 (load wins), next decrement exactly 10 cycles later.
REQ-030 led_state=3'b100 during countdown -> err=1 next cycle, both slots 8'b1011_1111, bcd_remaining frozen; then 3'b011 -> err=0, bcd_remaining=8'h12.
REQ-031 bcd_remaining=8'h07 -> tens slot 8'hFF, units slot glyph 7; dig_sel alternates every 2 cycles.
REQ-032 With COUNTDOWN_BLINK_EN, bcd_remaining=8'h02 -> seg=8'hFF for prescaler 5..9, glyph 2 for 0..4; without the macro, glyph 2 steady.
